ff_bank_cfg_ctrl: RTL and testbench

Configuration sequencer for a bank of N_FF mode-configurable flip-flops (plain, enable, async-reset, sync-set, negedge/async-set variants), modelling the FPGA-fabric configuration path. It accepts one mode code per flip-flop over a valid/ready handshake and serializes each code into the bank's configuration shift chain. When all codes are shifted in, it pulses a chain latch and then holds a global set/reset (GSR) for a fixed number of cycles. It sits between a host or bitstream loader and the configurable-FF bank.

---
 rtl/ff_bank_cfg_ctrl_pkg.sv | 25 ++
 rtl/ff_bank_cfg_ctrl_serializer.sv | 36 +++
 rtl/ff_bank_cfg_ctrl.sv | 125 ++++++++++++
 tb/tb_ff_bank_cfg_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_bank_cfg_ctrl_pkg.sv
// Mode codes and sequencer states shared by the FF bank
// configuration sequencer and its serializer.
package ff_bank_cfg_ctrl_pkg;

  localparam int MODE_DFF      = 0;
  localparam int MODE_DFFE     = 1;
  localparam int MODE_DFFER    = 2;
  localparam int MODE_DFFESS   = 3;
  localparam int MODE_DFFNES   = 4;
  localparam int MODE_RSVD_MIN = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_GSR,
    ST_DONE
  } state_e;

  function automatic logic is_rsvd(input logic [31:0] code);
    return code >= 32'(MODE_RSVD_MIN);
  endfunction

endpackage

// File: rtl/ff_bank_cfg_ctrl_serializer.sv
// Load/shift register for one mode word, LSB first,
// with a saturating bit counter flagging the final bit.
module ffcfg_serializer #(
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [MODE_W-1:0] data,
  input  logic              shift_en,
  output logic              sdo,
  output logic              last_bit
);

  localparam int CW = $clog2(MODE_W) + 1;

  logic [MODE_W-1:0] sreg_q;
  logic [CW-1:0]     cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= data;
      cnt_q  <= '0;
    end else if (shift_en) begin
      sreg_q <= sreg_q >> 1;
      cnt_q  <= last_bit ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign sdo      = sreg_q[0];
  assign last_bit = cnt_q == CW'(MODE_W - 1);

endmodule

// File: rtl/ff_bank_cfg_ctrl.sv
// Configuration sequencer: serializes one mode word per FF
// into the bank chain, then latches and pulses GSR.
module ff_bank_cfg_ctrl
  import ff_bank_cfg_ctrl_pkg::*;
#(
  parameter int N_FF       = 16,
  parameter int MODE_W     = 3,
  parameter int GSR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MODE_W-1:0] cfg_mode,
  output logic              chain_en,
  output logic              chain_sdo,
  output logic              chain_latch,
  output logic              gsr,
  output logic              busy,
  output logic              done,
  output logic              err_mode
);

  localparam int IW = $clog2(N_FF);
  localparam int GW = $clog2(GSR_CYCLES) + 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     ff_idx_q, ff_idx_d;
  logic [GW-1:0]     gsr_cnt_q, gsr_cnt_d;
  logic              err_q, err_d;
  logic              rsvd, load, sdo, last_bit;
  logic [MODE_W-1:0] load_data;

  assign rsvd      = is_rsvd(32'(cfg_mode));
  assign load      = state_q == ST_LOAD && cfg_valid && !abort;
  assign load_data = rsvd ? MODE_W'(MODE_DFF) : cfg_mode;

  ffcfg_serializer #(
    .MODE_W(MODE_W)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (load_data),
    .shift_en(state_q == ST_SHIFT),
    .sdo     (sdo),
    .last_bit(last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ff_idx_q  <= '0;
      gsr_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ff_idx_q  <= ff_idx_d;
      gsr_cnt_q <= gsr_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ff_idx_d  = ff_idx_q;
    gsr_cnt_d = gsr_cnt_q;
    err_d     = err_q;
    // abort beats every transition, including a same-cycle handshake
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ff_idx_d = '0;
          if (start && !abort) begin
            state_d = ST_LOAD;
            err_d   = 1'b0;
          end
        end
        ST_LOAD: begin
          if (cfg_valid) begin
            state_d = ST_SHIFT;
            if (rsvd) err_d = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            if (ff_idx_q == IW'(N_FF - 1)) begin
              state_d = ST_LATCH;
            end else begin
              ff_idx_d = ff_idx_q + 1'b1;
              state_d  = ST_LOAD;
            end
          end
        end
        ST_LATCH: begin
          gsr_cnt_d = '0;
          state_d   = ST_GSR;
        end
        ST_GSR: begin
          if (gsr_cnt_q == GW'(GSR_CYCLES - 1)) begin
            state_d = ST_DONE;
          end else begin
            gsr_cnt_d = gsr_cnt_q + 1'b1;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign cfg_ready   = state_q == ST_LOAD;
  assign chain_en    = state_q == ST_SHIFT;
  assign chain_sdo   = chain_en & sdo;
  assign chain_latch = state_q == ST_LATCH;
  assign gsr         = state_q == ST_GSR;
  assign done        = state_q == ST_DONE;
  assign busy        = state_q != ST_IDLE;
  assign err_mode    = err_q;

endmodule

// File: tb/tb_ff_bank_cfg_ctrl.sv
// Scoreboard bench for ff_bank_cfg_ctrl: chain bits are queued
// on each accepted word and popped as chain_en shifts them out.
module tb_ff_bank_cfg_ctrl;

  localparam int N_FF       = 4;
  localparam int MODE_W     = 3;
  localparam int GSR_CYCLES = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort, cfg_valid;
  logic [MODE_W-1:0] cfg_mode;
  logic              cfg_ready, chain_en, chain_sdo, chain_latch;
  logic              gsr, busy, done, err_mode;

  ff_bank_cfg_ctrl #(
    .N_FF      (N_FF),
    .MODE_W    (MODE_W),
    .GSR_CYCLES(GSR_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .chain_en   (chain_en),
    .chain_sdo  (chain_sdo),
    .chain_latch(chain_latch),
    .gsr        (gsr),
    .busy       (busy),
    .done       (done),
    .err_mode   (err_mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic              exp_q[$];
  logic [MODE_W-1:0] words[N_FF];
  int cyc = 0;
  int base = 0;
  int latch_at, latch_n, gsr_first, gsr_n, done_at, done_n;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (chain_en) begin
        if (exp_q.size() == 0) chk("sdo_extra", 32'(exp_q.size()), 1);
        else chk("sdo", 32'(chain_sdo), 32'(exp_q.pop_front()));
      end
      if (chain_latch) begin
        latch_n++;
        if (latch_at < 0) latch_at = cyc - base;
      end
      if (gsr) begin
        gsr_n++;
        if (gsr_first < 0) gsr_first = cyc - base;
      end
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = cyc - base;
      end
    end
  end

  task automatic clear_mon();
    latch_at = -1; latch_n = 0;
    gsr_first = -1; gsr_n = 0;
    done_at = -1; done_n = 0;
  endtask

  // cycle 1 is the cycle after the edge that samples start
  task automatic begin_pass(input bit hold);
    clear_mon();
    start = 1'b1;
    base  = cyc;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("pass_busy", busy, 1);
    chk("pass_err_clr", err_mode, 0);
  endtask

  task automatic send_word(input logic [MODE_W-1:0] m);
    int n;
    n = 0;
    cfg_mode  = m;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      chk("ready_timeout", n, 0);
    end else begin
      for (int b = 0; b < MODE_W; b++)
        exp_q.push_back(m >= 5 ? 1'b0 : m[b]);
      @(negedge clk);
    end
  endtask

  task automatic run_words(input int stall_idx, input int stall_n);
    bit rs;
    int n;
    rs = 1'b0;
    for (int i = 0; i < N_FF; i++) begin
      if (i == stall_idx) begin
        cfg_valid = 1'b0;
        n = 0;
        while (!cfg_ready && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < stall_n; k++) begin
          chk("stall_ready", cfg_ready, 1);
          chk("stall_chain_en", chain_en, 0);
          @(negedge clk);
        end
      end
      send_word(words[i]);
      rs |= (words[i] >= 5);
      chk("err_mode_word", err_mode, 32'(rs));
    end
  endtask

  task automatic finish_pass(input int lat, input int dn);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    cfg_valid = 1'b0;
    chk("busy_drop", busy, 0);
    chk("latch_cyc", latch_at, lat);
    chk("latch_cnt", latch_n, 1);
    chk("gsr_first", gsr_first, lat + 1);
    chk("gsr_cnt", gsr_n, GSR_CYCLES);
    chk("done_cyc", done_at, dn);
    chk("done_cnt", done_n, 1);
    chk("sdo_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_mode = '0;
    clear_mon();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_outs", {chain_en, chain_sdo, chain_latch, gsr, done}, 0);
    chk("rst_err", err_mode, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // nominal pass, no stalls
    words = '{3'd1, 3'd2, 3'd3, 3'd4};
    begin_pass(1'b0);
    chk("load_ready", cfg_ready, 1);
    run_words(-1, 0);
    finish_pass(17, 22);
    chk("err_end", err_mode, 0);

    // three-cycle valid stall before the second word
    words = '{3'd1, 3'd2, 3'd3, 3'd4};
    begin_pass(1'b0);
    run_words(1, 3);
    finish_pass(20, 25);

    // reserved codes shift out as MODE_DFF and set err_mode
    words = '{3'd1, 3'd6, 3'd0, 3'd7};
    begin_pass(1'b0);
    run_words(-1, 0);
    finish_pass(17, 22);
    chk("err_held", err_mode, 1);

    // abort on the second shift bit of FF2
    clear_mon();
    begin_pass(1'b0);
    send_word(3'd7);
    chk("abort_err_set", err_mode, 1);
    send_word(3'd2);
    send_word(3'd3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cfg_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_chain_en", chain_en, 0);
    chk("abort_left", 32'(exp_q.size()), 1);
    exp_q.delete();
    repeat (30) @(negedge clk);
    chk("abort_latch", latch_n, 0);
    chk("abort_gsr", gsr_n, 0);
    chk("abort_done", done_n, 0);
    chk("abort_err_kept", err_mode, 1);

    // normal pass after abort
    words = '{3'd4, 3'd3, 3'd2, 3'd1};
    begin_pass(1'b0);
    run_words(-1, 0);
    finish_pass(17, 22);

    // async reset while gsr is high
    words = '{3'd1, 3'd2, 3'd3, 3'd4};
    begin_pass(1'b0);
    run_words(-1, 0);
    n = 0;
    while (!gsr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("gsr_seen", gsr, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gsr", gsr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_outs", {cfg_ready, chain_en, chain_latch, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cfg_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", cfg_ready, 0);
    cfg_valid = 1'b0;

    // start held high through a whole pass
    words = '{3'd2, 3'd4, 3'd1, 3'd3};
    begin_pass(1'b1);
    run_words(-1, 0);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("hold_busy", busy, 0);
    chk("hold_done_cyc", done_at, 22);
    chk("hold_done_cnt", done_n, 1);
    chk("hold_latch_cyc", latch_at, 17);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sa_busy", busy, 0);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
